// File: rtl/interpolator.sv
// Sample-rate interpolator: each accepted input sample is followed by
// INTERPOLATION_FACTOR-1 further outputs, either zeros (zero stuffing) or
// repeats of the sample (zero-order hold). A sticky underrun flag records
// any period boundary at which no new input sample was available.
module interpolator #(
  parameter int DATA_WIDTH           = 16,
  parameter int INTERPOLATION_FACTOR = 3,
  parameter bit ZERO_STUFF           = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_enable,
  input  logic signed [DATA_WIDTH-1:0] interp_in,
  input  logic                         interp_in_valid,
  output logic                         interp_in_ready,
  output logic signed [DATA_WIDTH-1:0] interp_out,
  output logic                         interp_out_valid,
  output logic                         interp_out_first,
  output logic                         underrun,
  input  logic                         underrun_clr
);

  localparam int PHASE_WIDTH = $clog2(INTERPOLATION_FACTOR);
  localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(INTERPOLATION_FACTOR - 1);
  localparam logic [PHASE_WIDTH-1:0] FIRST_FILL = PHASE_WIDTH'(1);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t                         state;
  state_t                         state_next;
  logic [PHASE_WIDTH-1:0]         phase;
  logic [PHASE_WIDTH-1:0]         phase_next;
  logic signed [DATA_WIDTH-1:0]   hold;
  logic signed [DATA_WIDTH-1:0]   hold_next;
  logic signed [DATA_WIDTH-1:0]   out_next;
  logic                           valid_next;
  logic                           first_next;
  logic                           underrun_next;
  logic                           accept;
  logic                           period_missed;

  // A new sample can enter only between periods, and only on an enabled cycle.
  assign interp_in_ready = clk_enable && (state == IDLE || phase == '0);
  assign accept          = interp_in_valid && interp_in_ready;

  // A period boundary with nothing to start: emission stops and underrun is flagged.
  assign period_missed   = clk_enable && state == EMIT && phase == '0 && !accept;

  // State register: FSM state and index of the next output within the period.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  // Next-state logic: start a period on accept, otherwise step through it.
  // NOTE: every always_comb output is defaulted first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    phase_next = phase;
    if (accept) begin
      state_next = EMIT;
      phase_next = FIRST_FILL;
    end else if (clk_enable && state == EMIT) begin
      if (phase == '0) begin
        state_next = IDLE;
      end else if (phase == LAST_PHASE) begin
        phase_next = '0;
      end else begin
        phase_next = phase + 1'b1;
      end
    end
  end

  // Output logic: next values of the registered sample, flags and hold register.
  always_comb begin
    out_next   = interp_out;
    hold_next  = hold;
    valid_next = 1'b0;
    first_next = 1'b0;
    if (accept) begin
      hold_next  = interp_in;
      out_next   = interp_in;
      valid_next = 1'b1;
      first_next = 1'b1;
    end else if (clk_enable && state == EMIT && phase != '0) begin
      out_next   = ZERO_STUFF ? '0 : hold;
      valid_next = 1'b1;
    end

    // Setting wins over a simultaneous clear so a missed period is never lost.
    if (period_missed) begin
      underrun_next = 1'b1;
    end else if (underrun_clr) begin
      underrun_next = 1'b0;
    end else begin
      underrun_next = underrun;
    end
  end

  // Output and datapath registers; underrun_clr acts even while disabled.
  // NOTE: the hold register is a plain register, not a memory, so it is
  // reset with the rest of the state and never exposes stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold             <= '0;
      interp_out       <= '0;
      interp_out_valid <= 1'b0;
      interp_out_first <= 1'b0;
      underrun         <= 1'b0;
    end else begin
      hold             <= hold_next;
      interp_out       <= out_next;
      interp_out_valid <= valid_next;
      interp_out_first <= first_next;
      underrun         <= underrun_next;
    end
  end

endmodule

// File: tb/tb_interpolator.sv
// Directed bench for interpolator: a zero-stuffing instance and a
// zero-order-hold instance share one stimulus stream.
module tb_interpolator;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clk_enable;
  logic signed [W-1:0] interp_in;
  logic                interp_in_valid;
  logic                underrun_clr;

  logic                ready_zs, valid_zs, first_zs, underrun_zs;
  logic signed [W-1:0] out_zs;
  logic                ready_zoh, valid_zoh, first_zoh, underrun_zoh;
  logic signed [W-1:0] out_zoh;

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] samples [5] = '{16'sd100, -16'sd200, 16'sd300, 16'sh7FFF, 16'sh8000};
  logic signed [W-1:0] exp_zs;

  always #5 clk = ~clk;

  interpolator #(
    .DATA_WIDTH(W), .INTERPOLATION_FACTOR(3), .ZERO_STUFF(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .interp_in(interp_in), .interp_in_valid(interp_in_valid),
    .interp_in_ready(ready_zs), .interp_out(out_zs),
    .interp_out_valid(valid_zs), .interp_out_first(first_zs),
    .underrun(underrun_zs), .underrun_clr(underrun_clr)
  );

  interpolator #(
    .DATA_WIDTH(W), .INTERPOLATION_FACTOR(3), .ZERO_STUFF(1'b0)
  ) dut_zoh (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .interp_in(interp_in), .interp_in_valid(interp_in_valid),
    .interp_in_ready(ready_zoh), .interp_out(out_zoh),
    .interp_out_valid(valid_zoh), .interp_out_first(first_zoh),
    .underrun(underrun_zoh), .underrun_clr(underrun_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    clk_enable      = 1'b0;
    interp_in       = '0;
    interp_in_valid = 1'b0;
    underrun_clr    = 1'b0;

    // Reset state, before any clock edge.
    #3;
    check("rst_out", out_zs, 32'd0);
    check("rst_valid", valid_zs, 32'd0);
    check("rst_first", first_zs, 32'd0);
    check("rst_underrun", underrun_zs, 32'd0);
    check("rst_ready_disabled", ready_zs, 32'd0);
    clk_enable = 1'b1;
    #1;
    check("rst_ready_enabled", ready_zs, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous stream: 100,-200,300 then 0x7FFF,0x8000, no gaps.
    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 0) begin
        interp_in       = samples[i / 3];
        interp_in_valid = 1'b1;
      end
      check("stream_ready", ready_zs, (i % 3 == 0) ? 32'd1 : 32'd0);
      step();
      exp_zs = (i % 3 == 0) ? samples[i / 3] : 16'sd0;
      check("stream_zs_out", out_zs, exp_zs);
      check("stream_zs_valid", valid_zs, 32'd1);
      check("stream_zs_first", first_zs, (i % 3 == 0) ? 32'd1 : 32'd0);
      check("stream_zoh_out", out_zoh, samples[i / 3]);
      check("stream_zoh_first", first_zoh, (i % 3 == 0) ? 32'd1 : 32'd0);
    end
    interp_in_valid = 1'b0;

    // Missed period boundary sets underrun; outputs hold.
    step();
    check("miss_valid", valid_zs, 32'd0);
    check("miss_underrun", underrun_zs, 32'd1);
    check("miss_zoh_underrun", underrun_zoh, 32'd1);
    check("miss_out_hold", out_zs, 32'd0);
    check("miss_zoh_hold", out_zoh, samples[4]);
    check("miss_ready", ready_zs, 32'd1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("clr_underrun", underrun_zs, 32'd0);

    // Idle with no input: nothing happens, underrun unchanged.
    step();
    check("idle_valid", valid_zs, 32'd0);
    check("idle_first", first_zs, 32'd0);
    check("idle_underrun", underrun_zs, 32'd0);

    // Single sample 5, then underrun set with a simultaneous clear.
    interp_in       = 16'sd5;
    interp_in_valid = 1'b1;
    step();
    interp_in_valid = 1'b0;
    check("s5_out0", out_zs, 32'd5);
    check("s5_first0", first_zs, 32'd1);
    step();
    check("s5_out1", out_zs, 32'd0);
    check("s5_first1", first_zs, 32'd0);
    step();
    check("s5_out2", out_zs, 32'd0);
    check("s5_valid2", valid_zs, 32'd1);
    underrun_clr = 1'b1;
    step();
    check("s5_end_valid", valid_zs, 32'd0);
    check("set_beats_clr", underrun_zs, 32'd1);
    step();
    underrun_clr = 1'b0;
    check("s5_clr", underrun_zs, 32'd0);

    // Sample 7 with clk_enable low for two cycles after its first output.
    interp_in       = 16'sd7;
    interp_in_valid = 1'b1;
    step();
    interp_in_valid = 1'b0;
    check("s7_out0", out_zs, 32'd7);
    clk_enable = 1'b0;
    check("s7_ready_disabled", ready_zs, 32'd0);
    step();
    check("s7_stall1_valid", valid_zs, 32'd0);
    check("s7_stall1_out", out_zs, 32'd7);
    step();
    check("s7_stall2_valid", valid_zs, 32'd0);
    check("s7_stall2_zoh", out_zoh, 32'd7);
    clk_enable = 1'b1;
    step();
    check("s7_out1", out_zs, 32'd0);
    check("s7_valid1", valid_zs, 32'd1);
    check("s7_zoh1", out_zoh, 32'd7);
    step();
    check("s7_out2", out_zs, 32'd0);
    check("s7_valid2", valid_zs, 32'd1);
    step();
    check("s7_end_underrun", underrun_zs, 32'd1);
    clk_enable   = 1'b0;
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("clr_while_disabled", underrun_zs, 32'd0);
    clk_enable = 1'b1;

    // Asynchronous reset in the middle of sample 9's period.
    interp_in       = 16'sd9;
    interp_in_valid = 1'b1;
    step();
    interp_in_valid = 1'b0;
    check("s9_out0", out_zs, 32'd9);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", out_zs, 32'd0);
    check("async_rst_valid", valid_zs, 32'd0);
    check("async_rst_first", first_zs, 32'd0);
    check("async_rst_zoh", out_zoh, 32'd0);
    #2 rst_n = 1'b1;
    interp_in_valid = 1'b1;
    step();
    interp_in_valid = 1'b0;
    check("post_rst_out0", out_zs, 32'd9);
    check("post_rst_first0", first_zs, 32'd1);
    step();
    check("post_rst_out1", out_zs, 32'd0);
    check("post_rst_zoh1", out_zoh, 32'd9);
    step();
    check("post_rst_out2", out_zs, 32'd0);
    check("post_rst_valid2", valid_zs, 32'd1);
    step();
    check("post_rst_underrun", underrun_zs, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
